// File: rtl/tpu_sequencer.sv
// Decodes host instructions into operand-memory writes and sequences one skewed compute pass over the systolic array.
// Latency: LOAD/STORE effects one cycle after accept; first read enable two cycles after START; done at START+RUN_LEN+2.
// Backpressure: instr_ready is low only during the single DONE cycle; other states accept every valid instruction.
module tpu_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_SIZE = 4,
    parameter int IDX_W      = $clog2(ARRAY_SIZE),
    parameter int CNT_W      = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        instr_valid,
    input  logic [15:0]                 instr,
    output logic                        instr_ready,
    output logic                        mema_write_enable,
    output logic [IDX_W-1:0]            mema_write_line,
    output logic [IDX_W-1:0]            mema_write_elem,
    output logic [DATA_WIDTH-1:0]       mema_data_in,
    output logic                        memb_write_enable,
    output logic [IDX_W-1:0]            memb_write_line,
    output logic [IDX_W-1:0]            memb_write_elem,
    output logic [DATA_WIDTH-1:0]       memb_data_in,
    output logic [ARRAY_SIZE-1:0]       mema_read_enable,
    output logic [IDX_W*ARRAY_SIZE-1:0] mema_read_elem,
    output logic [ARRAY_SIZE-1:0]       memb_read_enable,
    output logic [IDX_W*ARRAY_SIZE-1:0] memb_read_elem,
    output logic                        array_clear,
    output logic                        array_write_enable,
    output logic [IDX_W-1:0]            array_output_row,
    output logic [IDX_W-1:0]            array_output_column,
    output logic                        result_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        instr_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    // Last counter value of a pass: the skew needs ARRAY_SIZE steps plus ARRAY_SIZE-1 of stagger on each side.
    localparam logic [CNT_W-1:0] RUN_LEN = CNT_W'(3 * ARRAY_SIZE - 2);

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic                  accept;
    logic [1:0]            op;
    logic                  is_stop;
    logic [IDX_W-1:0]      f_row;
    logic [IDX_W-1:0]      f_col;
    logic [DATA_WIDTH-1:0] f_imm;
    logic                  in_run;
    logic [ARRAY_SIZE-1:0] rd_en;
    logic [IDX_W*ARRAY_SIZE-1:0] rd_elem;
    logic                  unused_reserved;

    // Instruction field extraction and status decode.
    assign op              = instr[15:14];
    assign is_stop         = (op == OP_STOP);
    assign f_row           = IDX_W'(instr[11:10]);
    assign f_col           = IDX_W'(instr[9:8]);
    assign f_imm           = DATA_WIDTH'(instr[7:0]);
    assign unused_reserved = instr[12];

    assign instr_ready        = (state != S_DONE);
    assign accept             = instr_valid & instr_ready;
    assign in_run             = (state == S_RUN);
    assign busy               = (state == S_CLEAR) || in_run;
    assign array_clear        = (state == S_CLEAR);
    assign array_write_enable = in_run;
    assign done               = (state == S_DONE);

    // Skewed read window: line i is active for ARRAY_SIZE cycles starting at counter i+1, stepping its element select.
    for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_rd
        localparam logic [CNT_W-1:0] LO = CNT_W'(g + 1);
        localparam logic [CNT_W-1:0] HI = CNT_W'(g + ARRAY_SIZE);
        logic [IDX_W-1:0] off;
        assign off = IDX_W'(cnt - LO);
        assign rd_en[g] = in_run && (cnt >= LO) && (cnt <= HI);
        assign rd_elem[g*IDX_W +: IDX_W] = rd_en[g] ? off : '0;
    end

    assign mema_read_enable = rd_en;
    assign memb_read_enable = rd_en;
    assign mema_read_elem   = rd_elem;
    assign memb_read_elem   = rd_elem;

    // Pass FSM, pass counter and registered instruction side effects.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_IDLE;
            cnt                 <= '0;
            mema_write_enable   <= 1'b0;
            mema_write_line     <= '0;
            mema_write_elem     <= '0;
            mema_data_in        <= '0;
            memb_write_enable   <= 1'b0;
            memb_write_line     <= '0;
            memb_write_elem     <= '0;
            memb_data_in        <= '0;
            array_output_row    <= '0;
            array_output_column <= '0;
            result_valid        <= 1'b0;
            instr_err           <= 1'b0;
        end else begin
            mema_write_enable <= 1'b0;
            memb_write_enable <= 1'b0;
            result_valid      <= 1'b0;
            instr_err         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_START: state <= S_CLEAR;
                            OP_LOAD: begin
                                if (instr[13]) begin
                                    memb_write_enable <= 1'b1;
                                    memb_write_line   <= f_row;
                                    memb_write_elem   <= f_col;
                                    memb_data_in      <= f_imm;
                                end else begin
                                    mema_write_enable <= 1'b1;
                                    mema_write_line   <= f_row;
                                    mema_write_elem   <= f_col;
                                    mema_data_in      <= f_imm;
                                end
                            end
                            OP_STORE: begin
                                array_output_row    <= f_row;
                                array_output_column <= f_col;
                                result_valid        <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_CLEAR: begin
                    if (accept && is_stop) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        instr_err <= accept;
                        state     <= S_RUN;
                        cnt       <= CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (accept && is_stop) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        instr_err <= accept;
                        // Saturate rather than wrap; reaching the end always exits.
                        if (cnt >= RUN_LEN) begin
                            state <= S_DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_sequencer.sv
// Self-checking bench for tpu_sequencer: directed scenarios plus randomized traffic against a pass-timeline model.
// Latency: one clock per tick; outputs sampled 1ns after each rising edge.
// Backpressure: the model predicts instr_ready and only counts instructions the DUT can accept.
module tb_tpu_sequencer;

    localparam int AS      = 4;
    localparam int IW      = 2;
    localparam int DW      = 8;
    localparam int RUN_LEN = 3 * AS - 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            instr_valid = 1'b0;
    logic [15:0]     instr = 16'h0;
    logic            instr_ready;
    logic            mema_write_enable, memb_write_enable;
    logic [IW-1:0]   mema_write_line, mema_write_elem, memb_write_line, memb_write_elem;
    logic [DW-1:0]   mema_data_in, memb_data_in;
    logic [AS-1:0]   mema_read_enable, memb_read_enable;
    logic [IW*AS-1:0] mema_read_elem, memb_read_elem;
    logic            array_clear, array_write_enable;
    logic [IW-1:0]   array_output_row, array_output_column;
    logic            result_valid, busy, done, instr_err;

    int checks = 0;
    int failures = 0;

    tpu_sequencer #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .IDX_W(IW), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .mema_write_enable(mema_write_enable), .mema_write_line(mema_write_line),
        .mema_write_elem(mema_write_elem), .mema_data_in(mema_data_in),
        .memb_write_enable(memb_write_enable), .memb_write_line(memb_write_line),
        .memb_write_elem(memb_write_elem), .memb_data_in(memb_data_in),
        .mema_read_enable(mema_read_enable), .mema_read_elem(mema_read_elem),
        .memb_read_enable(memb_read_enable), .memb_read_elem(memb_read_elem),
        .array_clear(array_clear), .array_write_enable(array_write_enable),
        .array_output_row(array_output_row), .array_output_column(array_output_column),
        .result_valid(result_valid), .busy(busy), .done(done), .instr_err(instr_err)
    );

    always #5 clk = ~clk;

    // Reference model: a pass is a timeline measured in cycles since START was accepted.
    // m_k = 1 is the clear cycle, 2..RUN_LEN+1 are run cycles (counter = m_k-1), RUN_LEN+2 is the done cycle.
    bit          m_active = 0;
    int          m_k = 0;
    logic        m_wa = 0, m_wb = 0, m_rv = 0, m_err = 0;
    logic [IW-1:0] m_la = 0, m_ea = 0, m_lb = 0, m_eb = 0, m_orow = 0, m_ocol = 0;
    logic [DW-1:0] m_da = 0, m_db = 0;

    function automatic bit m_clear(); return m_active && m_k == 1; endfunction
    function automatic bit m_run();   return m_active && m_k >= 2 && m_k <= RUN_LEN + 1; endfunction
    function automatic bit m_done();  return m_active && m_k == RUN_LEN + 2; endfunction
    function automatic bit m_ready(); return !m_done(); endfunction
    function automatic bit m_busy();  return m_clear() || m_run(); endfunction

    function automatic logic [AS-1:0] m_rd_en();
        logic [AS-1:0] r;
        int c;
        r = '0;
        c = m_k - 1;
        for (int i = 0; i < AS; i++)
            r[i] = m_run() && c >= i + 1 && c <= i + AS;
        return r;
    endfunction

    function automatic logic [IW*AS-1:0] m_rd_elem();
        logic [IW*AS-1:0] r;
        logic [AS-1:0] en;
        int c;
        r = '0;
        en = m_rd_en();
        c = m_k - 1;
        for (int i = 0; i < AS; i++)
            if (en[i]) r[i*IW +: IW] = IW'((c - i - 1) % AS);
        return r;
    endfunction

    task automatic model_reset();
        m_active = 0; m_k = 0;
        m_wa = 0; m_wb = 0; m_rv = 0; m_err = 0;
        m_la = 0; m_ea = 0; m_lb = 0; m_eb = 0; m_orow = 0; m_ocol = 0;
        m_da = 0; m_db = 0;
    endtask

    task automatic model_step(input logic v, input logic [15:0] ins);
        bit acc;
        logic [1:0] op;
        acc = v && m_ready();
        op = ins[15:14];
        m_wa = 0; m_wb = 0; m_rv = 0; m_err = 0;
        if (!m_active) begin
            if (acc) begin
                if (op == 2'b00) begin
                    m_active = 1; m_k = 1;
                end else if (op == 2'b10 && ins[13]) begin
                    m_wb = 1; m_lb = ins[11:10]; m_eb = ins[9:8]; m_db = ins[7:0];
                end else if (op == 2'b10) begin
                    m_wa = 1; m_la = ins[11:10]; m_ea = ins[9:8]; m_da = ins[7:0];
                end else if (op == 2'b11) begin
                    m_rv = 1; m_orow = ins[11:10]; m_ocol = ins[9:8];
                end
            end
        end else if (m_busy()) begin
            if (acc && op == 2'b01) begin
                m_active = 0; m_k = 0;
            end else begin
                m_err = acc;
                m_k++;
            end
        end else begin
            m_active = 0; m_k = 0;
        end
    endtask

    task automatic tick(input logic v, input logic [15:0] ins);
        instr_valid = v;
        instr = ins;
        @(posedge clk);
        model_step(v, ins);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({instr_ready, busy, done, array_clear, array_write_enable, result_valid, instr_err} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=1000000", {instr_ready, busy, done, array_clear, array_write_enable, result_valid, instr_err});
        end
        // Leave non-zero registers behind, then reset in the middle of a run.
        tick(1, 16'hC600);
        tick(1, 16'h8E7F);
        tick(1, 16'hA53C);
        tick(1, 16'h0000);
        for (int j = 0; j < 4; j++) tick(0, 16'h0);
        checks++;
        if (busy !== 1'b1 || mema_read_enable === 4'b0000) begin
            failures++;
            $display("FAIL reset_pre_run busy=%b rd_en=%b want busy=1 rd_en!=0", busy, mema_read_enable);
        end
        apply_reset();
        checks++;
        if ({busy, mema_read_enable, memb_read_enable, mema_write_enable, memb_write_enable, array_write_enable} !== 12'h0) begin
            failures++;
            $display("FAIL reset_mid_run busy=%b rd_a=%b rd_b=%b we_a=%b we_b=%b awe=%b want all 0", busy, mema_read_enable, memb_read_enable, mema_write_enable, memb_write_enable, array_write_enable);
        end
        checks++;
        if ({array_output_row, array_output_column, mema_write_line, mema_data_in, memb_write_line, memb_data_in} !== 24'h0 || instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_regs row=%0d col=%0d la=%0d da=%h lb=%0d db=%h ready=%b want 0s ready=1", array_output_row, array_output_column, mema_write_line, mema_data_in, memb_write_line, memb_data_in, instr_ready);
        end
    endtask

    task automatic test_load();
        tick(1, 16'hA53C);
        checks++;
        if ({memb_write_enable, memb_write_line, memb_write_elem, memb_data_in, mema_write_enable} !== {1'b1, 2'd1, 2'd1, 8'h3C, 1'b0}) begin
            failures++;
            $display("FAIL load_b we_b=%b line=%0d elem=%0d data=%h we_a=%b want 1 1 1 3c 0", memb_write_enable, memb_write_line, memb_write_elem, memb_data_in, mema_write_enable);
        end
        tick(1, 16'h8E7F);
        checks++;
        if ({mema_write_enable, mema_write_line, mema_write_elem, mema_data_in, memb_write_enable} !== {1'b1, 2'd3, 2'd2, 8'h7F, 1'b0}) begin
            failures++;
            $display("FAIL load_a we_a=%b line=%0d elem=%0d data=%h we_b=%b want 1 3 2 7f 0", mema_write_enable, mema_write_line, mema_write_elem, mema_data_in, memb_write_enable);
        end
        tick(0, 16'h0);
        checks++;
        if ({mema_write_enable, memb_write_enable, mema_data_in, memb_data_in, memb_write_line} !== {2'b00, 8'h7F, 8'h3C, 2'd1}) begin
            failures++;
            $display("FAIL load_hold we_a=%b we_b=%b da=%h db=%h lb=%0d want 0 0 7f 3c 1", mema_write_enable, memb_write_enable, mema_data_in, memb_data_in, memb_write_line);
        end
    endtask

    task automatic test_start();
        tick(1, 16'h0000);
        for (int t = 1; t <= 13; t++) begin
            if (t > 1) tick(0, 16'h0);
            checks++;
            if (array_clear !== (t == 1) || busy !== (t >= 1 && t <= 11) || array_write_enable !== (t >= 2 && t <= 11) || done !== (t == 12) || instr_ready !== (t != 12)) begin
                failures++;
                $display("FAIL start_ctrl t=%0d clr=%b busy=%b awe=%b done=%b rdy=%b", t, array_clear, busy, array_write_enable, done, instr_ready);
            end
            checks++;
            if (mema_read_enable !== m_rd_en() || mema_read_elem !== m_rd_elem()) begin
                failures++;
                $display("FAIL start_read t=%0d en=%b elem=%h want en=%b elem=%h", t, mema_read_enable, mema_read_elem, m_rd_en(), m_rd_elem());
            end
            if (t == 2 || t == 5 || t == 11) begin
                checks++;
                if ((t == 2 && mema_read_enable !== 4'b0001) || (t == 5 && {mema_read_enable, mema_read_elem} !== {4'b1111, 8'h1B}) || (t == 11 && mema_read_enable !== 4'b0000)) begin
                    failures++;
                    $display("FAIL start_window t=%0d en=%b elem=%h", t, mema_read_enable, mema_read_elem);
                end
            end
        end
    endtask

    task automatic test_abort();
        bit saw_done;
        tick(1, 16'h0000);
        for (int t = 2; t <= 4; t++) tick(0, 16'h0);
        tick(1, 16'h4000);
        checks++;
        if ({busy, mema_read_enable, memb_read_enable, array_write_enable, instr_err} !== 11'h0) begin
            failures++;
            $display("FAIL abort busy=%b rd_a=%b rd_b=%b awe=%b err=%b want 0", busy, mema_read_enable, memb_read_enable, array_write_enable, instr_err);
        end
        saw_done = 0;
        for (int t = 0; t < 10; t++) begin
            tick(0, 16'h0);
            if (done === 1'b1) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL abort_no_done got done pulse want none");
        end
        tick(1, 16'h0000);
        for (int t = 2; t <= 12; t++) begin
            tick(0, 16'h0);
            if (t >= 11) begin
                checks++;
                if (done !== (t == 12)) begin
                    failures++;
                    $display("FAIL abort_rerun t=%0d done=%b want %b", t, done, t == 12);
                end
            end
        end
        tick(0, 16'h0);
    endtask

    task automatic test_err_in_run();
        tick(1, 16'h0000);
        for (int t = 2; t <= 4; t++) tick(0, 16'h0);
        tick(1, 16'h8501);
        checks++;
        if ({instr_err, mema_write_enable, memb_write_enable, busy} !== 4'b1001) begin
            failures++;
            $display("FAIL run_err err=%b we_a=%b we_b=%b busy=%b want 1 0 0 1", instr_err, mema_write_enable, memb_write_enable, busy);
        end
        for (int t = 6; t <= 12; t++) begin
            tick(0, 16'h0);
            checks++;
            if (done !== (t == 12) || instr_err !== 1'b0) begin
                failures++;
                $display("FAIL run_err_done t=%0d done=%b err=%b want done=%b err=0", t, done, instr_err, t == 12);
            end
        end
        tick(0, 16'h0);
    endtask

    task automatic test_store();
        tick(1, 16'hC600);
        checks++;
        if ({array_output_row, array_output_column, result_valid} !== {2'd1, 2'd2, 1'b1}) begin
            failures++;
            $display("FAIL store row=%0d col=%0d rv=%b want 1 2 1", array_output_row, array_output_column, result_valid);
        end
        for (int t = 0; t < 3; t++) begin
            tick(0, 16'h0);
            checks++;
            if ({array_output_row, array_output_column, result_valid, busy, mema_write_enable, memb_write_enable} !== {2'd1, 2'd2, 4'b0000}) begin
                failures++;
                $display("FAIL store_hold row=%0d col=%0d rv=%b busy=%b want 1 2 0 0", array_output_row, array_output_column, result_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ins;
        logic [1:0] op;
        int r;
        for (int cyc = 0; cyc < 800; cyc++) begin
            r = $urandom_range(0, 7);
            op = (r < 2) ? 2'b00 : (r == 2) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
            ins = {op, 14'($urandom)};
            if ($urandom_range(0, 99) < 3) begin
                apply_reset();
            end else begin
                tick(($urandom_range(0, 99) < 30), ins);
            end
            checks++;
            if ({instr_ready, busy, array_clear, array_write_enable, done, result_valid, instr_err} !== {m_ready(), m_busy(), m_clear(), m_run(), m_done(), m_rv, m_err}) begin
                failures++;
                $display("FAIL rnd_ctrl cyc=%0d got=%b want=%b", cyc, {instr_ready, busy, array_clear, array_write_enable, done, result_valid, instr_err}, {m_ready(), m_busy(), m_clear(), m_run(), m_done(), m_rv, m_err});
            end
            checks++;
            if ({mema_write_enable, mema_write_line, mema_write_elem, mema_data_in} !== {m_wa, m_la, m_ea, m_da} || {memb_write_enable, memb_write_line, memb_write_elem, memb_data_in} !== {m_wb, m_lb, m_eb, m_db}) begin
                failures++;
                $display("FAIL rnd_write cyc=%0d a=%h b=%h want a=%h b=%h", cyc, {mema_write_enable, mema_write_line, mema_write_elem, mema_data_in}, {memb_write_enable, memb_write_line, memb_write_elem, memb_data_in}, {m_wa, m_la, m_ea, m_da}, {m_wb, m_lb, m_eb, m_db});
            end
            checks++;
            if (mema_read_enable !== m_rd_en() || memb_read_enable !== m_rd_en() || mema_read_elem !== m_rd_elem() || memb_read_elem !== m_rd_elem()) begin
                failures++;
                $display("FAIL rnd_read cyc=%0d en_a=%b en_b=%b el_a=%h el_b=%h want en=%b el=%h", cyc, mema_read_enable, memb_read_enable, mema_read_elem, memb_read_elem, m_rd_en(), m_rd_elem());
            end
            checks++;
            if ({array_output_row, array_output_column} !== {m_orow, m_ocol}) begin
                failures++;
                $display("FAIL rnd_outsel cyc=%0d row=%0d col=%0d want %0d %0d", cyc, array_output_row, array_output_column, m_orow, m_ocol);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_start();
        test_abort();
        test_err_in_run();
        test_store();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
